// File: rtl/lfsr_uart_tx_if.sv
`default_nettype none
// ==== lfsr_uart_tx_if : word-source / serial-status bundle for lfsr_uart_tx (rev 1.0) ====
interface lfsr_uart_tx_if #(
   parameter int FIFO_AW = 2
);
   logic [7:0]       data_in;
   logic             data_valid;
   logic             tx;
   logic             busy;
   logic             overflow;
   logic [FIFO_AW:0] fifo_count;

   modport master (
      output data_in,
      output data_valid,
      input  tx,
      input  busy,
      input  overflow,
      input  fifo_count
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output tx,
      output busy,
      output overflow,
      output fifo_count
   );
endinterface
`default_nettype wire

// File: rtl/lfsr_uart_tx.sv
`default_nettype none
// ==== lfsr_uart_tx : buffers LFSR words in a small FIFO and sends each as a UART 8N1 frame (rev 1.0) ====
module lfsr_uart_tx #(
   parameter int CLOCK_HZ = 6000,
   parameter int BAUD     = 300,
   parameter int FIFO_AW  = 2
) (
   input  wire logic     clk,
   input  wire logic     reset_n,
   lfsr_uart_tx_if.slave bus
);

   localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int DEPTH        = 1 << FIFO_AW;

   localparam logic [CNT_W-1:0]   BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_baud
         $error("lfsr_uart_tx: CLOCK_HZ/BAUD must be at least 2");
      end
      if (FIFO_AW < 1) begin : g_bad_depth
         $error("lfsr_uart_tx: FIFO_AW must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     baud_q;
   logic [2:0]           bit_idx_q;
   logic [7:0]           shift_q;
   logic                 tx_q;

   logic [7:0]           mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q;
   logic [FIFO_AW-1:0]   rd_ptr_q;
   logic [FIFO_AW:0]     count_q;
   logic [FIFO_AW:0]     count_d;
   logic                 overflow_q;

   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_bit_end;

   // A full FIFO still accepts a word when the transmitter drains one in the same cycle.
   assign w_pop     = (state_q == S_IDLE) && (count_q != '0);
   assign w_push    = bus.data_valid && ((count_q != FULL_COUNT) || w_pop);
   assign w_drop    = bus.data_valid && !w_push;
   assign w_bit_end = (baud_q == BAUD_LAST);

   always_comb begin
      count_d = count_q;
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         if (w_drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (w_pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  state_q   <= S_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  baud_q  <= '0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     tx_q      <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  baud_q  <= '0;
                  tx_q    <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end

            default: begin
               baud_q  <= '0;
               tx_q    <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = (state_q != S_IDLE) || (count_q != '0);
   assign bus.overflow   = overflow_q;
   assign bus.fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_uart_tx.sv
`default_nettype none
// ==== tb_lfsr_uart_tx : randomized scoreboard bench for lfsr_uart_tx (rev 1.0) ====
module tb_lfsr_uart_tx;

   localparam int CLOCK_HZ = 8;
   localparam int BAUD     = 2;
   localparam int FIFO_AW  = 2;
   localparam int CPB      = CLOCK_HZ / BAUD;
   localparam int FRAME    = 10 * CPB;
   localparam int DEPTH    = 4;
   localparam int NEVER    = 32'h7fff_ffff;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;

   lfsr_uart_tx_if #(.FIFO_AW(FIFO_AW)) bus ();

   lfsr_uart_tx #(
      .CLOCK_HZ (CLOCK_HZ),
      .BAUD     (BAUD),
      .FIFO_AW  (FIFO_AW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      int         pop;
   } exp_t;

   exp_t exp_q[$];
   int   push_c[$];
   int   pop_c[$];
   int   last_pop  = -1000;
   int   rej_first = NEVER;
   int   n_checks  = 0;
   int   n_fails   = 0;

   logic [FRAME-1:0] frame_bits;
   int               fr_n     = 0;
   int               fr_start = 0;
   bit               in_frame = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: a word pushed at edge t is taken by the transmitter one edge later,
   // or one idle cycle after the previous frame's 10 bit-times, whichever is later.
   function automatic int m_count(input int k);
      int c = 0;
      foreach (push_c[i]) if (push_c[i] <= k && pop_c[i] > k) c++;
      return c;
   endfunction

   function automatic bit m_active(input int k);
      foreach (pop_c[i]) if (pop_c[i] <= k && k < pop_c[i] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_pop_at(input int k);
      foreach (pop_c[i]) if (pop_c[i] == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [63:0] m_wave(input logic [7:0] d);
      logic [63:0] w = '0;
      logic        b;
      for (int s = 0; s < 10; s++) begin
         if (s == 0)      b = 1'b0;
         else if (s == 9) b = 1'b1;
         else             b = d[s-1];
         for (int r = 0; r < CPB; r++) w[s*CPB + r] = b;
      end
      return w;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.data_in = 8'($urandom);
      end
   endtask

   task automatic strobe(input logic [7:0] d);
      int t;
      int p;
      t = cyc + 1;
      bus.data_in    = d;
      bus.data_valid = 1'b1;
      if (m_count(t - 1) < DEPTH || m_pop_at(t)) begin
         p = (t + 1 > last_pop + FRAME + 1) ? t + 1 : last_pop + FRAME + 1;
         push_c.push_back(t);
         pop_c.push_back(p);
         last_pop = p;
         exp_q.push_back('{data: d, pop: p});
      end else if (t < rej_first) begin
         rej_first = t;
      end
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.data_in    = 8'($urandom);
   endtask

   task automatic model_flush();
      exp_q.delete();
      push_c.delete();
      pop_c.delete();
      last_pop  = -1000;
      rej_first = NEVER;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || in_frame || cyc <= last_pop + FRAME) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         n_checks++;
         n_fails++;
         $display("FAIL %s_timeout: %0d frames still pending after %0d cycles", name, exp_q.size(), n);
      end
      idle(2);
      check({name, "_busy_after"}, 64'(bus.busy), 64'(0));
   endtask

   // Monitor: per-cycle status against the reference, frames decoded and scored.
   always @(negedge clk) begin
      if (!reset_n) begin
         in_frame = 1'b0;
         fr_n     = 0;
      end else begin
         check("fifo_count", 64'(bus.fifo_count), 64'(m_count(cyc)));
         check("busy", 64'(bus.busy), 64'(m_active(cyc) || (m_count(cyc) != 0)));
         check("overflow", 64'(bus.overflow), 64'(rej_first <= cyc));
         if (!in_frame && bus.tx == 1'b0) begin
            in_frame = 1'b1;
            fr_n     = 0;
            fr_start = cyc;
         end
         if (in_frame) begin
            frame_bits[fr_n] = bus.tx;
            fr_n++;
            if (fr_n == FRAME) begin
               in_frame = 1'b0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fails++;
                  $display("FAIL unexpected_frame: got wave %0h starting cycle %0d, expected none",
                           frame_bits, fr_start);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("frame_start", 64'(fr_start), 64'(e.pop));
                  check("frame_wave", 64'(frame_bits), m_wave(e.data));
               end
            end
         end
      end
   end

   initial begin
      bus.data_in    = 8'h00;
      bus.data_valid = 1'b0;
      reset_n        = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx", 64'(bus.tx), 64'(1));
      check("reset_busy", 64'(bus.busy), 64'(0));
      check("reset_overflow", 64'(bus.overflow), 64'(0));
      check("reset_count", 64'(bus.fifo_count), 64'(0));
      reset_n = 1'b1;
      idle(50);

      strobe(8'hA5);
      wait_drain("single");

      strobe(8'h00);
      strobe(8'hFF);
      wait_drain("b2b");

      strobe(8'h11);
      strobe(8'h22);
      strobe(8'h33);
      strobe(8'h44);
      strobe(8'h55);
      strobe(8'h66);
      wait_drain("overflow");
      check("overflow_sticky", 64'(bus.overflow), 64'(1));

      strobe(8'h5A);
      strobe(8'h01);
      strobe(8'h02);
      idle(8);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset_tx", 64'(bus.tx), 64'(1));
      check("midreset_count", 64'(bus.fifo_count), 64'(0));
      check("midreset_busy", 64'(bus.busy), 64'(0));
      check("midreset_overflow", 64'(bus.overflow), 64'(0));
      model_flush();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle(60);

      for (int i = 0; i < 10; i++) begin
         strobe(8'($urandom));
         idle(44);
      end
      wait_drain("wrap");

      for (int i = 0; i < 40; i++) begin
         strobe(8'($urandom));
         idle($urandom_range(0, 50));
      end
      wait_drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lfsr_uart_tx.md
Name: lfsr_uart_tx

Overview:
- Downstream consumer of the LFSR core: captures 8-bit LFSR output words on a step strobe and buffers them in a 4-entry FIFO.
- Serializes each buffered word as a UART 8N1 frame on a single pin, so the pseudo-random stream can be logged off-chip through one output bit.
- Sits between the LFSR core output bus and the top-level io_out.

Parameters:
- CLOCK_HZ, 6000: system clock frequency in Hz.
- BAUD, 300: UART bit rate. CLKS_PER_BIT = CLOCK_HZ/BAUD (integer division), must be >= 2; elaboration error otherwise.
- FIFO_AW, 2: FIFO address width. Depth = 2**FIFO_AW = 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  8  LFSR state word.
- data_valid  in  1  one-cycle strobe: data_in holds a new word to enqueue.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- fifo_count  out  FIFO_AW+1  number of words currently buffered (0..4).

Behaviour:
- Reset: asserting reset_n low immediately forces tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, baud counter=0, bit index=0, FIFO pointers=0. Async assert, sync deassert by the system.
- Reset mid-frame: frame aborted, tx high at once, buffered words discarded.
- FIFO:
  - Push when data_valid=1 and (count<4 or pop occurs in the same cycle).
  - Pop when FSM=IDLE and count>0.
  - Simultaneous push and pop leaves count unchanged.
  - Push attempt while count=4 with no same-cycle pop: word dropped, overflow set to 1. overflow is cleared only by reset.
  - Pointers wrap modulo 4.
- FSM states and transitions:
  - IDLE: tx=1. If count>0, pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit 7, go to STOP. Bits are sent LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
- Latency, starting from IDLE with an empty FIFO:
  - Strobe sampled at edge E writes the FIFO.
  - At edge E+1 the FSM pops and enters START.
  - tx first goes low in the cycle after edge E+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly one IDLE cycle (tx=1) between the end of STOP and the next START.
- tx is driven directly from a register with no combinational glitch path.
- busy = (FSM != IDLE) or (count != 0). It is registered-equivalent, with no dependence on data_valid in the same cycle.
- data_in is sampled only on a push; changes while data_valid=0 are ignored.

Test Plan (CLOCK_HZ=8, BAUD=2, so CLKS_PER_BIT=4):
- Reset check: hold reset_n=0 for 3 cycles, then release -> tx=1, busy=0, overflow=0, fifo_count=0, and tx stays 1 for 50 idle cycles.
- Single byte: one data_valid with data_in=0xA5 -> tx low for 4 cycles starting 2 cycles after the strobe edge. Data bits 1,0,1,0,0,1,0,1, 4 cycles each. Stop bit high for 4 cycles. busy falls to 0 at the 40-cycle frame end.
- Back-to-back: strobes 0x00 then 0xFF on consecutive cycles -> two 40-cycle frames separated by exactly 1 high cycle. The second frame's data bits are all 1.
- Overflow: six consecutive strobes 0x11,0x22,0x33,0x44,0x55,0x66 from idle -> 0x11 popped on cycle 2 alongside the 0x22 push. fifo_count peaks at 4. 0x66 dropped and overflow=1. Exactly 5 frames 0x11..0x55 are sent, then busy=0 with overflow still 1.
- Reset mid-frame: pulse reset_n low during the DATA state of 0x5A with 2 words queued -> tx=1 within the same cycle, fifo_count=0, busy=0, and no further frames are sent.
- Wrap-around: 10 words are sent with strobes spaced 45 cycles apart -> all 10 frames decode correctly, overflow stays 0, and the FIFO pointers wrap past index 3 without corrupting data.
